// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences the shared ALU, unified memory port and register file.
// Define MEM_WAIT_EN to honour mem_ready wait states; otherwise every memory access takes one cycle.
module mc_ctrl_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IorD,
   output logic               RegWrite,
   output logic               GPRSel,
   output logic               WDSel,
   output logic               EXTOp,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [3:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               instr_done,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      IEXEC  = 4'd10,
      IWB    = 4'd11
   } state_e;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111;
   localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_AND = 6'b100100;
   localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_SLL = 6'b000000, F_SRL = 6'b000010;
   localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3;
   localparam logic [3:0] ALU_OR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_LUI = 4'd8;

   state_e     state_q, state_d;
   logic       memReady;
   logic       legal;
   logic [3:0] rAluOp;

`ifdef MEM_WAIT_EN
   assign memReady = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign memReady = 1'b1;
`endif

   // Instruction legality and R-type ALU function, decoded straight from the IR fields.
   always_comb begin
      rAluOp = ALU_NOP;
      case (Funct)
         F_ADDU:  rAluOp = ALU_ADD;
         F_SUBU:  rAluOp = ALU_SUB;
         F_AND:   rAluOp = ALU_AND;
         F_OR:    rAluOp = ALU_OR;
         F_SLT:   rAluOp = ALU_SLT;
         F_SLL:   rAluOp = ALU_SLL;
         F_SRL:   rAluOp = ALU_SRL;
         default: rAluOp = ALU_NOP;
      endcase
      case (Op)
         OP_R:                                      legal = (rAluOp != ALU_NOP);
         OP_LW, OP_SW, OP_BEQ, OP_J,
         OP_ADDIU, OP_ORI, OP_LUI:                  legal = 1'b1;
         default:                                   legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= FETCH;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = memReady ? DECODE : FETCH;
         DECODE: begin
            if (!legal)                                    state_d = FETCH;
            else if (Op == OP_LW || Op == OP_SW)           state_d = MEMADR;
            else if (Op == OP_R)                           state_d = EXEC;
            else if (Op == OP_BEQ)                         state_d = BRANCH;
            else if (Op == OP_J)                           state_d = JUMP;
            else                                           state_d = IEXEC;
         end
         MEMADR: state_d = (Op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  state_d = memReady ? MEMWB : MEMRD;
         MEMWR:  state_d = memReady ? FETCH : MEMWR;
         EXEC:   state_d = RWB;
         IEXEC:  state_d = IWB;
         default: state_d = FETCH;
      endcase
   end

   // Outputs are Moore on state, except the mem_ready-dependent strobes and the Zero-gated branch write.
   always_comb begin
      PCWrite = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0;
      RegWrite = 1'b0; GPRSel = 1'b0; WDSel = 1'b0; EXTOp = 1'b0;
      ALUSrcA = 2'd0; ALUSrcB = 2'd0; ALUOp = ALU_NOP; PCSource = 2'd0;
      instr_done = 1'b0; illegal = 1'b0;
      if (rst) begin
         case (state_q)
            FETCH: begin
               MemRead = 1'b1; ALUSrcB = 2'd1; ALUOp = ALU_ADD;
               IRWrite = memReady; PCWrite = memReady;
            end
            DECODE: begin
               ALUSrcB = 2'd3; EXTOp = 1'b1; ALUOp = ALU_ADD;
               illegal = !legal; instr_done = !legal;
            end
            MEMADR: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; EXTOp = 1'b1; ALUOp = ALU_ADD; end
            MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
            MEMWB:  begin RegWrite = 1'b1; GPRSel = 1'b1; WDSel = 1'b1; instr_done = 1'b1; end
            MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; instr_done = memReady; end
            EXEC: begin
               ALUSrcA = (Funct == F_SLL || Funct == F_SRL) ? 2'd2 : 2'd1;
               ALUOp = rAluOp;
            end
            RWB:    begin RegWrite = 1'b1; instr_done = 1'b1; end
            BRANCH: begin
               ALUSrcA = 2'd1; ALUOp = ALU_SUB; PCSource = 2'd1; PCWrite = Zero; instr_done = 1'b1;
            end
            JUMP:   begin PCSource = 2'd2; PCWrite = 1'b1; instr_done = 1'b1; end
            IEXEC: begin
               ALUSrcA = 2'd1; ALUSrcB = 2'd2;
               case (Op)
                  OP_ADDIU: begin EXTOp = 1'b1; ALUOp = ALU_ADD; end
                  OP_ORI:   ALUOp = ALU_OR;
                  OP_LUI:   ALUOp = ALU_LUI;
                  default:  ALUOp = ALU_NOP;
               endcase
            end
            IWB:    begin RegWrite = 1'b1; GPRSel = 1'b1; instr_done = 1'b1; end
            default: ;
         endcase
      end
   end

   assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction table, hand-built corner sequences and random
// instructions checked cycle by cycle against a phase-list reference model.
module tb_mc_ctrl_fsm;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_BAD = 6'b111111;

   typedef struct packed {
      logic [3:0] st;
      logic       pcW, irW, mRd, mWr, iorD, rW, gpr, wd, ext;
      logic [1:0] srcA, srcB;
      logic [3:0] aluOp;
      logic [1:0] pcSrc;
      logic       done, ill;
   } outs_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      int         cycles;
      int         regWrites;
      int         memWrites;
      int         pcWrites;
      int         illegals;
      int         aluOp3;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, Zero, mem_ready;
   logic [5:0] Op, Funct;
   logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, GPRSel, WDSel, EXTOp;
   logic [1:0] ALUSrcA, ALUSrcB, PCSource;
   logic [3:0] ALUOp;
   logic       instr_done, illegal;
   logic [3:0] state;

   int checks = 0;
   int fails = 0;
   int seqQ[$];
   vec_t vecs[18];

   mc_ctrl_fsm #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
      .RegWrite(RegWrite), .GPRSel(GPRSel), .WDSel(WDSel), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=still running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct, input logic zero);
      Op = op;
      Funct = funct;
      Zero = zero;
   endtask

   function automatic outs_t dutOuts();
      outs_t o;
      o = {state, PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, GPRSel, WDSel, EXTOp,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal};
      return o;
   endfunction

   function automatic int functAluOp(input logic [5:0] funct);
      case (funct)
         6'b100001: return 1;
         6'b100011: return 2;
         6'b100100: return 3;
         6'b100101: return 4;
         6'b101010: return 5;
         6'b000000: return 6;
         6'b000010: return 7;
         default:   return 0;
      endcase
   endfunction

   function automatic bit isLegal(input logic [5:0] op, input logic [5:0] funct);
      if (op == OP_R) return functAluOp(funct) != 0;
      return op inside {OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDIU, OP_ORI, OP_LUI};
   endfunction

   // The sequence of states an instruction walks through, ignoring wait cycles.
   task automatic buildSeq(input logic [5:0] op, input logic [5:0] funct);
      seqQ.delete();
      seqQ.push_back(0);
      seqQ.push_back(1);
      if (isLegal(op, funct)) begin
         case (op)
            OP_LW:  begin seqQ.push_back(2); seqQ.push_back(3); seqQ.push_back(4); end
            OP_SW:  begin seqQ.push_back(2); seqQ.push_back(5); end
            OP_R:   begin seqQ.push_back(6); seqQ.push_back(7); end
            OP_BEQ: seqQ.push_back(8);
            OP_J:   seqQ.push_back(9);
            default: begin seqQ.push_back(10); seqQ.push_back(11); end
         endcase
      end
   endtask

   function automatic outs_t expectOuts(input int p, input logic [5:0] op, input logic [5:0] funct,
                                         input logic zero, input logic ready);
      outs_t e;
      e = '0;
      e.st = 4'(p);
      case (p)
         0:  begin e.mRd = 1; e.srcB = 2'd1; e.aluOp = 4'd1; e.irW = ready; e.pcW = ready; end
         1:  begin
            e.srcB = 2'd3; e.ext = 1; e.aluOp = 4'd1;
            e.ill = !isLegal(op, funct); e.done = !isLegal(op, funct);
         end
         2:  begin e.srcA = 2'd1; e.srcB = 2'd2; e.ext = 1; e.aluOp = 4'd1; end
         3:  begin e.mRd = 1; e.iorD = 1; end
         4:  begin e.rW = 1; e.gpr = 1; e.wd = 1; e.done = 1; end
         5:  begin e.mWr = 1; e.iorD = 1; e.done = ready; end
         6:  begin
            e.srcA = (funct == 6'b000000 || funct == 6'b000010) ? 2'd2 : 2'd1;
            e.aluOp = 4'(functAluOp(funct));
         end
         7:  begin e.rW = 1; e.done = 1; end
         8:  begin e.srcA = 2'd1; e.aluOp = 4'd2; e.pcSrc = 2'd1; e.pcW = zero; e.done = 1; end
         9:  begin e.pcSrc = 2'd2; e.pcW = 1; e.done = 1; end
         10: begin
            e.srcA = 2'd1; e.srcB = 2'd2;
            if (op == OP_ADDIU) begin e.ext = 1; e.aluOp = 4'd1; end
            else if (op == OP_ORI) e.aluOp = 4'd4;
            else e.aluOp = 4'd8;
         end
         11: begin e.rW = 1; e.gpr = 1; e.done = 1; end
         default: ;
      endcase
      return e;
   endfunction

   // Runs one instruction with random mem_ready, comparing every cycle against the model.
   task automatic runModelInstr(input logic [5:0] op, input logic [5:0] funct, input logic zero);
      int  p;
      int  waits;
      bit  effReady;
      bit  again;
      applyStimulus(op, funct, zero);
      buildSeq(op, funct);
      foreach (seqQ[i]) begin
         p = seqQ[i];
         waits = 0;
         do begin
            mem_ready = ($urandom_range(0, 3) != 0) || (waits >= 3);
`ifdef MEM_WAIT_EN
            effReady = mem_ready;
`else
            effReady = 1'b1;
`endif
            @(negedge clk);
            checkOutput($sformatf("model op=%b funct=%b phase=%0d", op, funct, p),
                        32'(dutOuts()), 32'(expectOuts(p, op, funct, zero, effReady)));
            @(posedge clk); #1;
            waits++;
            again = (p == 0 || p == 3 || p == 5) && !effReady;
         end while (again);
      end
   endtask

   // Runs one table entry with zero wait states, accumulating per-instruction totals.
   task automatic runVector(input vec_t v, input int idx);
      int cyc = 0, regW = 0, memW = 0, pcW = 0, ill = 0, alu3 = -1;
      bit done = 1'b0;
      applyStimulus(v.op, v.funct, v.zero);
      mem_ready = 1'b1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         regW += int'(RegWrite);
         memW += int'(MemWrite);
         pcW  += int'(PCWrite);
         ill  += int'(illegal);
         if (cyc == 2) alu3 = int'(ALUOp);
         done = instr_done;
         cyc++;
         @(posedge clk); #1;
      end
      checkOutput($sformatf("vec%0d cycles", idx), 32'(cyc), 32'(v.cycles));
      checkOutput($sformatf("vec%0d RegWrite count", idx), 32'(regW), 32'(v.regWrites));
      checkOutput($sformatf("vec%0d MemWrite count", idx), 32'(memW), 32'(v.memWrites));
      checkOutput($sformatf("vec%0d PCWrite count", idx), 32'(pcW), 32'(v.pcWrites));
      checkOutput($sformatf("vec%0d illegal count", idx), 32'(ill), 32'(v.illegals));
      if (v.cycles >= 3)
         checkOutput($sformatf("vec%0d ALUOp in cycle 3", idx), 32'(alu3), 32'(v.aluOp3));
   endtask

   // sw with mem_ready low for three MEMWR cycles; without MEM_WAIT_EN the stall must be ignored.
   task automatic swWaitSequence();
      int cyc = 0, memW = 0, doneCycle = -1;
      applyStimulus(OP_SW, 6'd0, 1'b0);
      while (doneCycle < 0 && cyc < 20) begin
`ifdef MEM_WAIT_EN
         mem_ready = !(cyc >= 3 && cyc <= 5);
`else
         mem_ready = 1'b0;
`endif
         @(negedge clk);
         memW += int'(MemWrite);
         if (instr_done) doneCycle = cyc;
         cyc++;
         @(posedge clk); #1;
      end
`ifdef MEM_WAIT_EN
      checkOutput("sw wait total cycles", 32'(cyc), 32'd7);
      checkOutput("sw wait MemWrite cycles", 32'(memW), 32'd4);
      checkOutput("sw wait instr_done cycle", 32'(doneCycle), 32'd6);
`else
      checkOutput("sw no-wait total cycles", 32'(cyc), 32'd4);
      checkOutput("sw no-wait MemWrite cycles", 32'(memW), 32'd1);
      checkOutput("sw no-wait instr_done cycle", 32'(doneCycle), 32'd3);
`endif
   endtask

   // Reset pulled mid-MEMWR must drop the write strobe at once; recovery restarts from FETCH.
   task automatic resetInMemwr();
      applyStimulus(OP_SW, 6'd0, 1'b0);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      #2;
      checkOutput("pre-reset MEMWR state", 32'(state), 32'd5);
      checkOutput("pre-reset MemWrite", 32'(MemWrite), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("async reset outputs", 32'(dutOuts()), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      applyStimulus(OP_J, 6'd0, 1'b0);
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("post-reset FETCH", 32'(dutOuts()), 32'(expectOuts(0, OP_J, 6'd0, 1'b0, 1'b1)));
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("post-reset DECODE state", 32'(state), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("post-reset JUMP", 32'(dutOuts()), 32'(expectOuts(9, OP_J, 6'd0, 1'b0, 1'b1)));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [5:0] opPool[9];
      logic [5:0] functPool[8];
      rst = 1'b0;
      mem_ready = 1'b0;
      applyStimulus(6'd0, 6'd0, 1'b0);

      vecs[0]  = '{OP_LW,    6'b000000, 1'b0, 5, 1, 0, 1, 0, 1};
      vecs[1]  = '{OP_SW,    6'b000000, 1'b0, 4, 0, 1, 1, 0, 1};
      vecs[2]  = '{OP_R,     6'b100001, 1'b0, 4, 1, 0, 1, 0, 1};
      vecs[3]  = '{OP_R,     6'b100011, 1'b0, 4, 1, 0, 1, 0, 2};
      vecs[4]  = '{OP_R,     6'b100100, 1'b0, 4, 1, 0, 1, 0, 3};
      vecs[5]  = '{OP_R,     6'b100101, 1'b0, 4, 1, 0, 1, 0, 4};
      vecs[6]  = '{OP_R,     6'b101010, 1'b0, 4, 1, 0, 1, 0, 5};
      vecs[7]  = '{OP_R,     6'b000000, 1'b0, 4, 1, 0, 1, 0, 6};
      vecs[8]  = '{OP_R,     6'b000010, 1'b0, 4, 1, 0, 1, 0, 7};
      vecs[9]  = '{OP_BEQ,   6'b000000, 1'b1, 3, 0, 0, 2, 0, 2};
      vecs[10] = '{OP_BEQ,   6'b000000, 1'b0, 3, 0, 0, 1, 0, 2};
      vecs[11] = '{OP_J,     6'b000000, 1'b0, 3, 0, 0, 2, 0, 0};
      vecs[12] = '{OP_ADDIU, 6'b000000, 1'b0, 4, 1, 0, 1, 0, 1};
      vecs[13] = '{OP_ORI,   6'b000000, 1'b0, 4, 1, 0, 1, 0, 4};
      vecs[14] = '{OP_LUI,   6'b000000, 1'b0, 4, 1, 0, 1, 0, 8};
      vecs[15] = '{OP_BAD,   6'b000000, 1'b0, 2, 0, 0, 1, 1, 0};
      vecs[16] = '{OP_R,     6'b000001, 1'b0, 2, 0, 0, 1, 1, 0};
      vecs[17] = '{6'b000101, 6'b000000, 1'b1, 2, 0, 0, 1, 1, 0};

      opPool = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDIU, OP_ORI, OP_LUI};
      functPool = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b000000,
                    6'b000010, 6'b111000};

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset outputs", 32'(dutOuts()), 32'd0);
      applyStimulus(OP_LW, 6'd0, 1'b1);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset held across edge", 32'(dutOuts()), 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 18; i++) runVector(vecs[i], i);

      swWaitSequence();
      resetInMemwr();

      runModelInstr(OP_LW, 6'd0, 1'b0);
      runModelInstr(OP_R, 6'b100001, 1'b0);
      runModelInstr(OP_R, 6'b000000, 1'b0);
      runModelInstr(OP_BEQ, 6'd0, 1'b1);
      runModelInstr(OP_BEQ, 6'd0, 1'b0);
      runModelInstr(OP_BAD, 6'd0, 1'b0);

      for (int n = 0; n < 150; n++) begin
         logic [5:0] op;
         logic [5:0] funct;
         op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : opPool[$urandom_range(0, 8)];
         funct = (op == OP_R) ? functPool[$urandom_range(0, 7)] : 6'($urandom);
         runModelInstr(op, funct, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the MIPS core: sequences a shared ALU, a single unified memory port and the register file across FETCH/DECODE/EXEC/MEM/WB states.
- Replaces the single-cycle combinational decoder when the datapath is split with IR, A/B and ALUOut registers.
- Outputs drive datapath muxes and write enables.
- Supports wait-stated memory through a ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the `state` debug output.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register load
- IRWrite  out  1  IR load
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- RegWrite  out  1  RF write
- GPRSel  out  1  RF write address: 0=rd, 1=rt
- WDSel  out  1  RF write data: 0=ALUOut, 1=MDR
- EXTOp  out  1  immediate extension: 1=sign, 0=zero
- ALUSrcA  out  2  ALU A: 0=PC, 1=A reg, 2=shamt
- ALUSrcB  out  2  ALU B: 0=B reg, 1=const 4, 2=Imm32, 3=Imm32<<2
- ALUOp  out  4  ALU op: 1=ADD, 2=SUB, 3=AND, 4=OR, 5=SLT, 6=SLL, 7=SRL, 8=LUI, 0=NOP
- PCSource  out  2  next PC: 0=ALU result, 1=ALUOut, 2={PC[31:28],IMM26,2'b00}
- instr_done  out  1  pulses in the last cycle of every instruction
- illegal  out  1  pulses in DECODE on an unsupported Op/Funct
- state  out  STATE_W  current state, for debug

Behaviour:
- Reset:
  - While rst=0, state=FETCH(0).
  - All write/request enables (PCWrite, IRWrite, MemRead, MemWrite, RegWrite), instr_done and illegal are forced to 0.
  - Mux selects are 0.
  - Deassertion takes effect on the next rising edge; an in-progress access is abandoned immediately.
- Moore outputs are decoded from state. Exceptions: PCWrite in BRANCH is gated by Zero; FETCH/MEMRD/MEMWR depend on mem_ready.
- Supported instructions:
  - R-type (Op=000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010, sll 000000, srl 000010.
  - lw 100011, sw 101011, beq 000100, j 000010, addiu 001001, ori 001101, lui 001111.
- States and actions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0. When mem_ready: IRWrite=1, PCWrite=1, next DECODE; otherwise stay with both writes 0.
  - DECODE(1): ALUSrcA=0, ALUSrcB=3, EXTOp=1, ALUOp=ADD (branch target into ALUOut). Next state by Op: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addiu/ori/lui→IEXEC. Illegal: illegal=1, instr_done=1, next FETCH.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=2, EXTOp=1, ALUOp=ADD. Next MEMRD (lw) or MEMWR (sw).
  - MEMRD(3): MemRead=1, IorD=1. Stay until mem_ready, then MEMWB.
  - MEMWB(4): RegWrite=1, GPRSel=1, WDSel=1, instr_done=1. Next FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. instr_done=1 in the mem_ready cycle, then FETCH.
  - EXEC(6): ALUSrcB=0. ALUSrcA=2 for sll/srl, else 1. ALUOp from Funct. Next RWB.
  - RWB(7): RegWrite=1, GPRSel=0, WDSel=0, instr_done=1. Next FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1, PCWrite=Zero, instr_done=1. Next FETCH.
  - JUMP(9): PCSource=2, PCWrite=1, instr_done=1. Next FETCH.
  - IEXEC(10): ALUSrcA=1, ALUSrcB=2. addiu: EXTOp=1, ADD. ori: EXTOp=0, OR. lui: EXTOp=0, LUI. Next IWB.
  - IWB(11): RegWrite=1, GPRSel=1, WDSel=0, instr_done=1. Next FETCH.
- Unused state codes recover to FETCH with all enables 0.
- Latency with zero wait states, in cycles: lw 5; sw, R-type and I-type 4; beq and j 3. Each wait cycle on mem_ready adds one cycle.
- At most one of MemRead/MemWrite is high in any cycle. RegWrite and MemWrite are never high together.

Optional Feature:
- Macro MEM_WAIT_EN.
- Defined: mem_ready is honoured as described above.
- Undefined: mem_ready is ignored and treated as constant 1. FETCH, MEMRD and MEMWR each last exactly one cycle. The port remains present but unused.

Test Plan:
- lw, mem_ready=1 → states 0,1,2,3,4. RegWrite=1, GPRSel=1, WDSel=1 only in cycle 5. instr_done once.
- addu then sll → EXEC ALUOp=1 with ALUSrcA=1, then ALUOp=6 with ALUSrcA=2. RegWrite with GPRSel=0 in cycle 4 of each.
- beq with Zero=1, then Zero=0 → PCWrite=1 / PCWrite=0 in BRANCH, PCSource=1. Back to FETCH after 3 cycles either way.
- MEM_WAIT_EN, sw with mem_ready low for 3 cycles in MEMWR → MemWrite held 4 cycles, instr_done only in the ready cycle. Total 7 cycles.
- rst pulled low in MEMWR → MemWrite drops to 0 asynchronously, state=0. After release, first cycle is FETCH.
- Op=111111 → illegal=1 and instr_done=1 in DECODE, no RF/mem/PC write, then FETCH.
